// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: pixel width, default frame geometry,
// the pixel type and the counter-width helper used by the line and window
// buffers.
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int DEF_COLS = 5;
  localparam int DEF_ROWS = 5;

  typedef logic [PIX_W-1:0] pixel_t;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image row of pixel storage. Single address, asynchronous read,
// synchronous write: a read and a write to the same address in one cycle
// return the old contents (read-before-write), which is what lets one
// memory both shift a row down and capture the new one.
module line_ram
  import img_pkg::*;
#(
  parameter int DEPTH = DEF_COLS,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o
);

  pixel_t mem_q [DEPTH];

  // Capture the write data at the addressed column.
  // NOTE: the array has no reset on purpose; stale rows are masked by the row
  // counter upstream, and a resettable array could not map to distributed RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_buffer_3rows.sv
// Raster-stream line buffer: keeps the two previous rows in circular line
// memories and emits, per accepted pixel, the vertically aligned column
// triple (row r-2, row r-1, row r). Triples are flagged valid from row 2
// onward; the last triple of every frame also raises progress_done_o.
module line_buffer_3rows
  import img_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic [PIX_W-1:0] data_i,
  output logic [PIX_W-1:0] S1_o,
  output logic [PIX_W-1:0] S2_o,
  output logic [PIX_W-1:0] S3_o,
  output logic             done_o,
  output logic             progress_done_o
);

  localparam int CW = cnt_w(COLS);
  localparam int RW = cnt_w(ROWS);

  localparam logic [CW-1:0] COL_LAST        = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST        = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pixel_t        s1_q, s1_d;
  pixel_t        s2_q, s2_d;
  pixel_t        s3_q, s3_d;
  logic          done_q, done_d;
  logic          prog_q, prog_d;

  pixel_t        l1_rd;
  pixel_t        l2_rd;
  logic          wr_en;

  // A pixel arriving together with reset is dropped, memories included.
  assign wr_en = done_i & ~rst;

  // L1 holds the previous row, L2 the row before it; L2 is fed from L1's
  // pre-write value so both shift down in the same cycle.
  line_ram #(.DEPTH(COLS), .AW(CW)) u_l1 (
    .clk     (clk),
    .we_i    (wr_en),
    .addr_i  (col_q),
    .wdata_i (data_i),
    .rdata_o (l1_rd)
  );

  line_ram #(.DEPTH(COLS), .AW(CW)) u_l2 (
    .clk     (clk),
    .we_i    (wr_en),
    .addr_i  (col_q),
    .wdata_i (l1_rd),
    .rdata_o (l2_rd)
  );

  // Next-state: advance raster position and load the column triple on an
  // accepted pixel; otherwise hold data and drop the strobes.
  // NOTE: every signal gets a default before the if, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    done_d = 1'b0;
    prog_d = 1'b0;
    if (done_i) begin
      s3_d   = data_i;
      s2_d   = l1_rd;
      s1_d   = l2_rd;
      done_d = (row_q >= ROW_FIRST_VALID);
      prog_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position counters and output registers, synchronously reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      done_q <= 1'b0;
      prog_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      done_q <= done_d;
      prog_q <= prog_d;
    end
  end

  assign S1_o            = s1_q;
  assign S2_o            = s2_q;
  assign S3_o            = s3_q;
  assign done_o          = done_q;
  assign progress_done_o = prog_q;

endmodule
